// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter.
//   state_t         : measurement state (WAIT_FIRST until a reference rise is seen)
//   DEFAULT_TIMEOUT : clk cycles without a rise before timeout (1 s at 100 MHz)
package period_meter_pkg;

   typedef enum logic {
      WAIT_FIRST,
      MEASURE
   } state_t;

   localparam int unsigned DEFAULT_TIMEOUT = 100_000_000;

endpackage

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous input into the clk domain and produces
// single-cycle rise/fall pulses from the synchronized level.
//   clk      : system clock
//   rst      : synchronous, active-high reset (clears all flops to 0)
//   async_in : asynchronous input
//   rise     : one-cycle pulse on a synchronized 0->1 transition
//   fall     : one-cycle pulse on a synchronized 1->0 transition
module edge_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         s_prev <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         s_prev <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise =  sync_q[SYNC_STAGES-1] & ~s_prev;
   assign fall = ~sync_q[SYNC_STAGES-1] &  s_prev;

endmodule

// File: rtl/period_meter.sv
// Measures a periodic input in clk cycles: period, high time, the equivalent
// clock-divider setting, a lock flag and a no-activity timeout.
//   clk        : system clock
//   rst        : synchronous, active-high reset
//   sig_in     : signal to measure (asynchronous to clk)
//   period     : clk cycles between the last two detected rising edges
//   high_time  : clk cycles from the last rise to the following fall
//   div_equiv  : floor(period/2) - 1
//   meas_valid : one-cycle pulse when the measurement outputs update
//   locked     : consecutive periods agree within TOL
//   timeout    : no rise seen for TIMEOUT cycles
module period_meter
   import period_meter_pkg::*;
#(
   parameter int unsigned CNT_WIDTH   = 32,
   parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT,
   parameter int unsigned TOL         = 0,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sig_in,
   output logic [CNT_WIDTH-1:0] period,
   output logic [CNT_WIDTH-1:0] high_time,
   output logic [CNT_WIDTH-1:0] div_equiv,
   output logic                 meas_valid,
   output logic                 locked,
   output logic                 timeout
);

   localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] TOL_C     = CNT_WIDTH'(TOL);

   logic                 rise;
   logic                 fall;
   state_t               state;
   state_t               state_next;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] hi_cnt;
   logic [CNT_WIDTH-1:0] diff;
   logic                 fall_seen;
   logic                 have_prev;
   logic                 update;
   logic                 timeout_hit;

   edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_edge_sync (
      .clk     (clk),
      .rst     (rst),
      .async_in(sig_in),
      .rise    (rise),
      .fall    (fall)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= WAIT_FIRST;
      end else begin
         state <= state_next;
      end
   end

   // A rise always takes priority over a coincident timeout.
   always_comb begin
      state_next  = state;
      update      = 1'b0;
      timeout_hit = 1'b0;
      diff        = (cnt >= period) ? (cnt - period) : (period - cnt);
      if (rise) begin
         state_next = MEASURE;
         update     = (state == MEASURE);
      end else if (cnt == TIMEOUT_C) begin
         state_next  = WAIT_FIRST;
         timeout_hit = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         hi_cnt     <= '0;
         fall_seen  <= 1'b0;
         have_prev  <= 1'b0;
         period     <= '0;
         high_time  <= '0;
         div_equiv  <= '0;
         meas_valid <= 1'b0;
         locked     <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         meas_valid <= update;

         // Restart at 1 so the count at the next rise equals the rise spacing.
         if (rise) begin
            cnt <= ONE;
         end else if (cnt != '1) begin
            cnt <= cnt + ONE;
         end

         if (rise) begin
            fall_seen <= 1'b0;
         end else if (fall && state == MEASURE) begin
            fall_seen <= 1'b1;
            hi_cnt    <= cnt;
         end

         if (update) begin
            period    <= cnt;
            high_time <= fall_seen ? hi_cnt : cnt;
            div_equiv <= (cnt >> 1) - ONE;
            have_prev <= 1'b1;
         end else if (rise) begin
            have_prev <= 1'b0;
         end

         if (update) begin
            locked <= have_prev && (diff <= TOL_C);
         end else if (timeout_hit) begin
            locked <= 1'b0;
         end

         if (rise) begin
            timeout <= 1'b0;
         end else if (timeout_hit) begin
            timeout <= 1'b1;
         end
      end
   end

endmodule
